sisc_core: RTL and testbench

Parametrised multi-cycle SISC execution core: accepts one 32-bit instruction at a time over a valid/ready handshake, reads operands from an internal register file, executes on an internal ALU, updates a 4-bit status register and writes back. It is the next generation of the SISC top level, folding register file, ALU, status register and control FSM into one block. It adds configurable data width and register count, instruction back-pressure, a HALT state and an observable writeback port.

---
 rtl/sisc_core.sv | 198 +++++++++++++++++++
 tb/tb_sisc_core.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sisc_core.sv
// sisc_core: multi-cycle SISC execution core.
// The core fetches one instruction per handshake, reads operands from an internal
// register file and executes on an internal ALU. It then updates the {C,N,V,Z}
// status flags and writes the result back.
// Optional feature macro: SISC_SAT_EN. When it is defined, ADD/SUB/ADDI saturate
// on signed overflow instead of wrapping.
module sisc_core #(
  parameter int WIDTH = 32,
  parameter int NREGS = 16
) (
  input  logic             clk,
  input  logic             rst_f,
  input  logic [31:0]      instruction,
  input  logic             instr_valid,
  output logic             instr_ready,
  output logic [3:0]       stat,
  output logic             wb_valid,
  output logic [3:0]       wb_addr,
  output logic [WIDTH-1:0] wb_data,
  output logic             halted,
  input  logic [3:0]       dbg_addr,
  output logic [WIDTH-1:0] dbg_data
);

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXECUTE, S_WRITEBACK, S_HALT
  } state_t;

  localparam logic [3:0] OP_ALU  = 4'h1;
  localparam logic [3:0] OP_ADDI = 4'h2;
  localparam logic [3:0] OP_HALT = 4'hF;

  state_t state_q, state_d;

  logic signed [WIDTH-1:0] regs [16];

  // Fetch stage: latched instruction word and its fields
  logic [31:0] instr_p0;
  logic [3:0]  op_p0, rd_p0, rs_p0, rt_p0;
  logic [15:0] imm_p0;
  logic signed [WIDTH-1:0] imm_ext_p0, rs_val, rt_val;

  assign op_p0  = instr_p0[31:28];
  assign rd_p0  = instr_p0[27:24];
  assign rs_p0  = instr_p0[23:20];
  assign rt_p0  = instr_p0[19:16];
  assign imm_p0 = instr_p0[15:0];
  assign imm_ext_p0 = WIDTH'($signed(imm_p0));

  // Register reads return zero for any index at or above NREGS.
  assign rs_val   = (32'(rs_p0) < NREGS) ? regs[rs_p0] : '0;
  assign rt_val   = (32'(rt_p0) < NREGS) ? regs[rt_p0] : '0;
  assign dbg_data = (32'(dbg_addr) < NREGS) ? regs[dbg_addr] : '0;

  // Decode stage: latched operands and operation select
  logic signed [WIDTH-1:0] opa_p1, opb_p1;
  logic                    is_addi_p1;
  logic [2:0]              fn_p1;
  logic [3:0]              rd_p1;

  // Execute stage: ALU result and flags
  logic signed [WIDTH-1:0] alu_r, res_p2;
  logic [WIDTH:0]          sum_w;
  logic                    alu_c, alu_v;
  logic [3:0]              stat_d;

`ifdef SISC_SAT_EN
  // Clamp an overflowed signed sum to the extreme in the direction of operand a.
  function automatic logic signed [WIDTH-1:0] sat_ovf(input logic signed [WIDTH-1:0] r,
                                                      input logic ovf,
                                                      input logic a_neg);
    if (!ovf)
      return r;
    else if (a_neg)
      return {1'b1, {(WIDTH-1){1'b0}}};
    else
      return {1'b0, {(WIDTH-1){1'b1}}};
  endfunction
`endif

  // Next-state and handshake/status outputs of the control FSM
  always_comb begin
    state_d     = state_q;
    instr_ready = 1'b0;
    wb_valid    = 1'b0;
    halted      = 1'b0;
    case (state_q)
      S_FETCH: begin
        instr_ready = !rst_f;
        if (instr_valid) state_d = S_DECODE;
      end
      S_DECODE: begin
        case (op_p0)
          OP_HALT:         state_d = S_HALT;
          OP_ALU, OP_ADDI: state_d = S_EXECUTE;
          default:         state_d = S_FETCH;
        endcase
      end
      S_EXECUTE:   state_d = S_WRITEBACK;
      S_WRITEBACK: begin
        wb_valid = !rst_f;
        state_d  = S_FETCH;
      end
      S_HALT: begin
        halted  = 1'b1;
        state_d = S_HALT;
      end
      default: state_d = S_FETCH;
    endcase
  end

  // State register; reset aborts whatever instruction is in flight
  always_ff @(posedge clk) begin
    if (rst_f) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  // Capture the instruction word on handshake
  always_ff @(posedge clk) begin
    if (state_q == S_FETCH && instr_valid) instr_p0 <= instruction;
  end

  // Latch operands during DECODE; ADDI takes the sign-extended immediate as b
  always_ff @(posedge clk) begin
    if (state_q == S_DECODE) begin
      opa_p1     <= rs_val;
      opb_p1     <= (op_p0 == OP_ADDI) ? imm_ext_p0 : rt_val;
      is_addi_p1 <= (op_p0 == OP_ADDI);
      fn_p1      <= imm_p0[2:0];
      rd_p1      <= rd_p0;
    end
  end

  // ALU: raw result with carry and signed-overflow flags
  always_comb begin
    sum_w = '0;
    alu_r = '0;
    alu_c = 1'b0;
    alu_v = 1'b0;
    if (is_addi_p1 || fn_p1 == 3'd0) begin
      sum_w = {1'b0, opa_p1} + {1'b0, opb_p1};
      alu_r = sum_w[WIDTH-1:0];
      alu_c = sum_w[WIDTH];
      alu_v = (opa_p1[WIDTH-1] == opb_p1[WIDTH-1]) && (alu_r[WIDTH-1] != opa_p1[WIDTH-1]);
    end else begin
      case (fn_p1)
        3'd1: begin
          // C here is the carry of a + ~b + 1, i.e. 1 means no borrow
          sum_w = {1'b0, opa_p1} + {1'b0, ~opb_p1} + (WIDTH+1)'(1);
          alu_r = sum_w[WIDTH-1:0];
          alu_c = sum_w[WIDTH];
          alu_v = (opa_p1[WIDTH-1] != opb_p1[WIDTH-1]) && (alu_r[WIDTH-1] != opa_p1[WIDTH-1]);
        end
        3'd2: alu_r = opa_p1 & opb_p1;
        3'd3: alu_r = opa_p1 | opb_p1;
        3'd4: alu_r = opa_p1 ^ opb_p1;
        3'd5: alu_r = ~opa_p1;
        3'd6: begin
          alu_r = {opa_p1[WIDTH-2:0], 1'b0};
          alu_c = opa_p1[WIDTH-1];
        end
        default: begin
          alu_r = {1'b0, opa_p1[WIDTH-1:1]};
          alu_c = opa_p1[0];
        end
      endcase
    end
`ifdef SISC_SAT_EN
    res_p2 = sat_ovf(alu_r, alu_v, opa_p1[WIDTH-1]);
`else
    res_p2 = alu_r;
`endif
    stat_d = {alu_c, res_p2[WIDTH-1], alu_v, (res_p2 == '0)};
  end

  // Execute/writeback boundary: flags and writeback port are registered in EXECUTE
  always_ff @(posedge clk) begin
    if (rst_f) begin
      stat    <= 4'b0000;
      wb_addr <= 4'd0;
      wb_data <= '0;
    end else if (state_q == S_EXECUTE) begin
      stat    <= stat_d;
      wb_addr <= rd_p1;
      wb_data <= res_p2;
    end
  end

  // Register file write at the end of WRITEBACK; unimplemented indices drop the write
  always_ff @(posedge clk) begin
    if (rst_f) begin
      for (int i = 0; i < 16; i++) regs[i] <= '0;
    end else if (state_q == S_WRITEBACK && 32'(wb_addr) < NREGS) begin
      regs[wb_addr] <= wb_data;
    end
  end

endmodule

// File: tb/tb_sisc_core.sv
// Testbench for sisc_core (WIDTH=32, NREGS=8): directed cases plus randomized
// instruction streams checked every cycle against a transaction-level model.
module tb_sisc_core;
  localparam int W  = 32;
  localparam int NR = 8;
  localparam longint SMAX = 64'sh7FFF_FFFF;
  localparam longint SMIN = -64'sh8000_0000;

  logic          clk = 1'b0;
  logic          rst_f;
  logic [31:0]   instruction;
  logic          instr_valid;
  logic          instr_ready;
  logic [3:0]    stat;
  logic          wb_valid;
  logic [3:0]    wb_addr;
  logic [W-1:0]  wb_data;
  logic          halted;
  logic [3:0]    dbg_addr;
  logic [W-1:0]  dbg_data;

  always #5 clk = ~clk;

  sisc_core #(.WIDTH(W), .NREGS(NR)) dut (
    .clk(clk), .rst_f(rst_f), .instruction(instruction), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .stat(stat), .wb_valid(wb_valid), .wb_addr(wb_addr),
    .wb_data(wb_data), .halted(halted), .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  int n_cmp = 0;
  int n_fail = 0;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endfunction

  // Reference model: architectural state plus the cycle at which each effect appears
  logic [W-1:0] mregs [16];
  logic [3:0]   mstat;
  int           t = 0;
  int           edges = 0;
  int           ready_t, halt_t, st_t, wb_t, wr_t, e;
  logic [3:0]   p_addr, p_stat, m_op, m_rs, m_rt;
  logic [W-1:0] p_data, m_a, m_b;
  bit           rst_prev = 1'b1;
  bit           exp_wbv;
  int           wb_count = 0;
  logic [3:0]   last_wb_addr;
  logic [W-1:0] last_wb_data;
  bit           dbg_hold = 1'b1;
  int           acc_edge;

  function automatic void mexec(input logic [3:0] op, input logic [2:0] fn,
                                input logic [W-1:0] a, input logic [W-1:0] b,
                                output logic [W-1:0] r, output logic [3:0] f);
    longint sa, sb, st;
    logic [63:0] u;
    logic c, v, arith;
    c = 1'b0; v = 1'b0; arith = 1'b0; r = '0; st = 0;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (op == 4'h2 || fn == 3'd0) begin
      u = {32'b0, a} + {32'b0, b};
      r = u[31:0]; c = u[32]; st = sa + sb; arith = 1'b1;
    end else begin
      case (fn)
        3'd1: begin r = a - b; c = (a >= b); st = sa - sb; arith = 1'b1; end
        3'd2: r = a & b;
        3'd3: r = a | b;
        3'd4: r = a ^ b;
        3'd5: r = ~a;
        3'd6: begin r = a << 1; c = a[W-1]; end
        default: begin r = a >> 1; c = a[0]; end
      endcase
    end
    if (arith) v = (st > SMAX) || (st < SMIN);
`ifdef SISC_SAT_EN
    if (v) r = (st > 0) ? 32'h7FFF_FFFF : 32'h8000_0000;
`endif
    f = {c, r[W-1], v, (r == '0)};
  endfunction

  always @(posedge clk) edges++;

  // Compare process: advance the model one cycle, then check every output
  always @(negedge clk) begin
    t++;
    if (rst_prev) begin
      for (int i = 0; i < 16; i++) mregs[i] = '0;
      mstat = 4'b0; ready_t = t; halt_t = -1; st_t = -1; wb_t = -1; wr_t = -1;
    end
    if (t == st_t) mstat = p_stat;
    if (t == wr_t && p_addr < NR) mregs[p_addr] = p_data;
    exp_wbv = (t == wb_t) && !rst_f;
    chk("instr_ready", 64'(instr_ready), 64'(!rst_f && t >= ready_t));
    chk("wb_valid", 64'(wb_valid), 64'(exp_wbv));
    if (exp_wbv) begin
      chk("wb_addr", 64'(wb_addr), 64'(p_addr));
      chk("wb_data", 64'(wb_data), 64'(p_data));
    end
    if (wb_valid) begin
      wb_count++;
      last_wb_addr = wb_addr;
      last_wb_data = wb_data;
    end
    chk("halted", 64'(halted), 64'(halt_t >= 0 && t >= halt_t));
    chk("stat", 64'(stat), 64'(mstat));
    chk("dbg_data", 64'(dbg_data), 64'((dbg_addr < NR) ? mregs[dbg_addr] : '0));
    if (!rst_f && t >= ready_t && instr_valid) begin
      e = t + 1;
      m_op = instruction[31:28];
      m_rs = instruction[23:20];
      m_rt = instruction[19:16];
      if (m_op == 4'h1 || m_op == 4'h2) begin
        m_a = (m_rs < NR) ? mregs[m_rs] : '0;
        if (m_op == 4'h2) m_b = {{16{instruction[15]}}, instruction[15:0]};
        else              m_b = (m_rt < NR) ? mregs[m_rt] : '0;
        mexec(m_op, instruction[2:0], m_a, m_b, p_data, p_stat);
        p_addr = instruction[27:24];
        st_t = e + 2; wb_t = e + 2; wr_t = e + 3; ready_t = e + 3;
      end else if (m_op == 4'hF) begin
        halt_t = e + 1;
        ready_t = 1 << 30;
      end else begin
        ready_t = e + 1;
      end
    end
    rst_prev = rst_f;
  end

  function automatic logic [31:0] alu(input logic [2:0] fn, input logic [3:0] rd,
                                      input logic [3:0] rs, input logic [3:0] rt);
    return {4'h1, rd, rs, rt, 13'b0, fn};
  endfunction

  function automatic logic [31:0] addi(input logic [3:0] rd, input logic [3:0] rs,
                                       input logic [15:0] imm);
    return {4'h2, rd, rs, 4'h0, imm};
  endfunction

  // Present an instruction and wait (bounded) for its handshake.
  // Inputs only ever change shortly after a rising edge.
  task automatic issue(input logic [31:0] ins, input bit hold);
    if (!instr_valid) begin
      @(posedge clk);
      #1;
    end
    instruction = ins;
    instr_valid = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (instr_ready) begin
        @(posedge clk);
        #1;
        acc_edge = edges;
        if (!hold) instr_valid = 1'b0;
        return;
      end
    end
    n_cmp++;
    n_fail++;
    $display("FAIL issue_timeout: instruction %08h never accepted", ins);
    instr_valid = 1'b0;
  endtask

  task automatic run(input logic [31:0] ins);
    issue(ins, 1'b0);
    repeat (4) @(negedge clk);
    #1;
  endtask

  // Random debug-port address while no directed check owns it
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (!dbg_hold) dbg_addr = 4'($urandom_range(0, 15));
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int wbc, a0, a1, pick, nv;
    logic [31:0] ins;
    rst_f = 1'b1; instr_valid = 1'b0; instruction = '0; dbg_addr = 4'd0;
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    chk("rst_ready", 64'(instr_ready), 64'd0);
    chk("rst_wb_valid", 64'(wb_valid), 64'd0);
    chk("rst_wb_addr", 64'(wb_addr), 64'd0);
    chk("rst_wb_data", 64'(wb_data), 64'd0);
    chk("rst_stat", 64'(stat), 64'd0);
    chk("rst_halted", 64'(halted), 64'd0);
    @(posedge clk); #1 rst_f = 1'b0;
    @(negedge clk); #1;
    chk("ready_after_rst", 64'(instr_ready), 64'd1);
    dbg_hold = 1'b0;

    // ADDI r1,r0,#0x7FFF; ready stays low three cycles after acceptance
    issue(addi(4'd1, 4'd0, 16'h7FFF), 1'b0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); #1;
      chk("ready_gap", 64'(instr_ready), 64'(i == 3));
    end
    chk("addi_addr", 64'(last_wb_addr), 64'd1);
    chk("addi_data", 64'(last_wb_data), 64'h7FFF);
    chk("addi_stat", 64'(stat), 64'b0000);

    // r1 = 0x7FFFFFFF via ADDI -1 then SHR
    run(addi(4'd1, 4'd0, 16'hFFFF));
    run(alu(3'd7, 4'd1, 4'd1, 4'd0));
    chk("shr_data", 64'(last_wb_data), 64'h7FFF_FFFF);
    chk("shr_stat", 64'(stat), 64'b1000);
    run(alu(3'd0, 4'd2, 4'd1, 4'd1));
`ifdef SISC_SAT_EN
    chk("add_ovf_data", 64'(last_wb_data), 64'h7FFF_FFFF);
    chk("add_ovf_stat", 64'(stat), 64'b0010);
`else
    chk("add_ovf_data", 64'(last_wb_data), 64'hFFFF_FFFE);
    chk("add_ovf_stat", 64'(stat), 64'b0110);
`endif

    run(addi(4'd3, 4'd0, 16'd5));
    run(alu(3'd1, 4'd4, 4'd3, 4'd3));
    chk("sub_data", 64'(last_wb_data), 64'd0);
    chk("sub_stat", 64'(stat), 64'b1001);
    run(alu(3'd7, 4'd5, 4'd3, 4'd0));
    chk("shr5_data", 64'(last_wb_data), 64'd2);
    chk("shr5_stat", 64'(stat), 64'b1000);

    // Write to an unimplemented register still pulses wb_valid
    wbc = wb_count;
    run(addi(4'd12, 4'd0, 16'd1));
    chk("r12_pulses", 64'(wb_count - wbc), 64'd1);
    chk("r12_addr", 64'(last_wb_addr), 64'd12);
    chk("r12_data", 64'(last_wb_data), 64'd1);
    dbg_hold = 1'b1; dbg_addr = 4'd12;
    @(negedge clk); #1;
    chk("r12_dbg", 64'(dbg_data), 64'd0);
    dbg_addr = 4'd1;
    @(negedge clk); #1;
    chk("r1_dbg", 64'(dbg_data), 64'h7FFF_FFFF);
    dbg_hold = 1'b0;

    // Randomized stream: ALU ops, ADDI and NOP-class opcodes, random gaps and held valid
    repeat (250) begin
      pick = $urandom_range(0, 9);
      if (pick < 5)
        ins = alu(3'($urandom_range(0, 7)), 4'($urandom), 4'($urandom), 4'($urandom));
      else if (pick < 8)
        ins = addi(4'($urandom), 4'($urandom), 16'($urandom));
      else begin
        nv = $urandom_range(0, 12);
        ins = {((nv == 0) ? 4'h0 : 4'(nv + 2)), 28'($urandom)};
      end
      issue(ins, 1'($urandom_range(0, 1)));
      if (!instr_valid) repeat ($urandom_range(0, 3)) @(posedge clk);
    end
    @(posedge clk); #1 instr_valid = 1'b0;
    repeat (6) @(posedge clk);

    // Reset during EXECUTE of ADD r5 aborts it
    run(addi(4'd1, 4'd0, 16'd3));
    wbc = wb_count;
    issue(alu(3'd0, 4'd5, 4'd1, 4'd1), 1'b0);
    @(posedge clk); #1 rst_f = 1'b1;
    @(posedge clk); #1 rst_f = 1'b0;
    repeat (4) @(negedge clk); #1;
    chk("abort_no_wb", 64'(wb_count - wbc), 64'd0);
    chk("abort_stat", 64'(stat), 64'd0);
    dbg_hold = 1'b1; dbg_addr = 4'd5;
    @(negedge clk); #1;
    chk("abort_r5", 64'(dbg_data), 64'd0);
    dbg_addr = 4'd1;
    @(negedge clk); #1;
    chk("abort_r1", 64'(dbg_data), 64'd0);
    dbg_hold = 1'b0;

    // NOP, HALT, ADDI streamed with valid held high
    wbc = wb_count;
    issue(32'h0000_0000, 1'b1);
    a0 = acc_edge;
    issue(32'hF000_0000, 1'b1);
    a1 = acc_edge;
    chk("nop_cycles", 64'(a1 - a0), 64'd2);
    instruction = addi(4'd6, 4'd0, 16'd9);
    repeat (10) @(negedge clk); #1;
    chk("halt_halted", 64'(halted), 64'd1);
    chk("halt_ready", 64'(instr_ready), 64'd0);
    chk("halt_no_wb", 64'(wb_count - wbc), 64'd0);
    @(posedge clk); #1 rst_f = 1'b1; instr_valid = 1'b0;
    @(posedge clk); #1 rst_f = 1'b0;
    @(negedge clk); #1;
    chk("halt_cleared", 64'(halted), 64'd0);
    chk("halt_ready_back", 64'(instr_ready), 64'd1);
    repeat (2) @(posedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
